apb_cmd_master: RTL

Parametrised APB4 requester (master) driven by a valid/ready command port. It replaces the fixed-address, single-mode master.
- Accepts arbitrary read/write commands with address, data and byte strobes.
- Runs the IDLE/SETUP/ACCESS protocol and supports back-to-back transfers without returning to IDLE.
- Returns read data plus an error status (PSLVERR or wait-state timeout) on a one-cycle response pulse.
- Sits between an internal command source (sequencer/CPU bridge) and the APB peripheral fabric.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_wait_timer.sv | 33 +++
 rtl/apb_cmd_master.sv | 126 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master and its wait timer.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_RSP_DATA_W = 32;

  typedef struct packed {
    logic [APB_RSP_DATA_W-1:0] rdata;
    logic                      err;
    logic                      timeout;
  } apb_rsp_t;

  localparam int TIMEOUT_DISABLED = 0;

  // A disabled timer still keeps a 1-bit counter so the ports stay meaningful.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout == TIMEOUT_DISABLED) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the last permitted one.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = wait_cnt_w(TIMEOUT);
  localparam bit ENABLED = (TIMEOUT != TIMEOUT_DISABLED);
  localparam logic [CNT_W-1:0] LAST = ENABLED ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] r_cnt;

  // Saturates at LAST: reaching it always ends the transfer anyway.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (ENABLED && i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = ENABLED && (r_cnt == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester fed by a valid/ready command port, with wait-state timeout
// and a one-cycle response pulse.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 16,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [STRB_W-1:0] cmd_strb_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic [STRB_W-1:0] pstrb_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  apb_state_e        r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_strb;
  logic              r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_expired, w_done, w_timeout, w_ready, w_accept, w_active;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .i_clear   (r_state == ST_SETUP),
    .i_enable  ((r_state == ST_ACCESS) && !pready_i),
    .o_expired (w_expired)
  );

  // pready wins over a simultaneous expiry.
  assign w_done    = (r_state == ST_ACCESS) && (pready_i || w_expired);
  assign w_timeout = (r_state == ST_ACCESS) && !pready_i && w_expired;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= ST_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (cmd_valid_i) w_state_next = ST_SETUP;
      end
      ST_SETUP: w_state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (w_done) begin
          w_ready      = 1'b1;
          w_state_next = cmd_valid_i ? ST_SETUP : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Ready is forced low while reset is held, even though the state reads IDLE.
  assign cmd_ready_o = w_ready & preset_n;
  assign w_accept    = cmd_valid_i & w_ready;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_accept) begin
      r_addr  <= cmd_addr_i;
      r_write <= cmd_write_i;
      r_wdata <= cmd_write_i ? cmd_wdata_i : '0;
      r_strb  <= cmd_write_i ? cmd_strb_i : '0;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_rsp_valid <= w_done;
      if (w_done) begin
        r_rsp_err     <= w_timeout | (pready_i & pslverr_i);
        r_rsp_timeout <= w_timeout;
        r_rsp_rdata   <= (pready_i && !pslverr_i && !r_write) ? prdata_i : '0;
      end
    end
  end

  assign w_active  = (r_state != ST_IDLE);
  assign psel_o    = w_active;
  assign penable_o = (r_state == ST_ACCESS);
  assign paddr_o   = w_active ? r_addr : '0;
  assign pwrite_o  = w_active & r_write;
  assign pwdata_o  = w_active ? r_wdata : '0;
  assign pstrb_o   = w_active ? r_strb : '0;

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;
  assign rsp_rdata_o   = r_rsp_rdata;

endmodule
